// File: rtl/duty_ramp.sv
// Slew-limited half-bridge duty generator: duty walks toward a clamped target one STEP per clk_int tick.
// Optional macro DUTY_RAMP_SYNC_EN inserts a 2-flop synchronizer ahead of the clk_int edge detector.
module duty_ramp #(
  parameter int unsigned DUTY_MAX = 950,
  parameter int unsigned DUTY_MIN = 50,
  parameter int unsigned STEP     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       clk_int,
  input  logic       enable,
  input  logic       fault,
  input  logic [9:0] target,
  input  logic       target_valid,
  output logic [9:0] d_halfbridge,
  output logic       at_target,
  output logic       fault_latched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [9:0]  MAX_10 = 10'(DUTY_MAX);
  localparam logic [9:0]  MIN_10 = 10'(DUTY_MIN);
  localparam logic [10:0] MAX_W  = 11'(DUTY_MAX);
  localparam logic [10:0] MIN_W  = 11'(DUTY_MIN);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam bit          JUMP_TO_MIN = (DUTY_MIN > STEP);

  state_t     state;
  logic [9:0] tgt_q;
  logic       tick;

`ifdef DUTY_RAMP_SYNC_EN
  logic sync1_q, sync2_q, edge_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= clk_int;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~edge_q;
`else
  logic edge_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) edge_q <= 1'b0;
    else        edge_q <= clk_int;
  end

  assign tick = clk_int & ~edge_q;
`endif

  logic [9:0]  tgt_clamped;
  logic [9:0]  tgt_next;
  logic [10:0] eff;
  logic [10:0] duty_w;
  logic [10:0] duty_step;
  logic [9:0]  duty_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no inferred latch).
  always_comb begin
    tgt_clamped = target;
    if (target == '0)         tgt_clamped = '0;
    else if (target < MIN_10) tgt_clamped = MIN_10;
    else if (target > MAX_10) tgt_clamped = MAX_10;

    // A strobe coincident with a tick steers that tick toward the new target.
    tgt_next = (ce && target_valid) ? tgt_clamped : tgt_q;
    eff      = enable ? {1'b0, tgt_next} : '0;
    duty_w   = {1'b0, d_halfbridge};

    duty_step = duty_w;
    if (eff > duty_w) begin
      if (JUMP_TO_MIN && duty_w == '0)    duty_step = MIN_W;
      else if (eff - duty_w > STEP_W)     duty_step = duty_w + STEP_W;
      else                                duty_step = eff;
      if (duty_step > MAX_W)              duty_step = MAX_W;
    end else if (eff < duty_w) begin
      if (duty_w - eff > STEP_W)          duty_step = duty_w - STEP_W;
      else                                duty_step = eff;
      // Shutting down: anything below the minimum running duty snaps to off.
      if (eff == '0 && duty_step < MIN_W) duty_step = '0;
    end

    duty_next = duty_step[10] ? MAX_10 : duty_step[9:0];
  end

  // Reset is synchronous; fault outranks ce so a frozen block still shuts the bridge off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      d_halfbridge  <= '0;
      tgt_q         <= '0;
      at_target     <= 1'b0;
      fault_latched <= 1'b0;
    end else if (fault) begin
      state         <= FAULT;
      d_halfbridge  <= '0;
      at_target     <= 1'b0;
      fault_latched <= 1'b1;
    end else if (ce) begin
      case (state)
        IDLE: begin
          tgt_q        <= tgt_next;
          d_halfbridge <= '0;
          if (enable) state <= RAMP;
        end
        RAMP: begin
          tgt_q <= tgt_next;
          if (tick) d_halfbridge <= duty_next;
          if (duty_w == eff) begin
            if (enable) begin
              state     <= HOLD;
              at_target <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          tgt_q <= tgt_next;
          if (tick) d_halfbridge <= duty_next;
          if (!enable || duty_w != eff) begin
            state     <= RAMP;
            at_target <= 1'b0;
          end
        end
        FAULT: begin
          if (!enable) begin
            state         <= IDLE;
            tgt_q         <= '0;
            fault_latched <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: directed scenarios plus randomized traffic against a behavioural model.
module tb_duty_ramp;

  localparam int DUTY_MAX = 950;
  localparam int DUTY_MIN = 50;
  localparam int STEP     = 4;
`ifdef DUTY_RAMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       clk_int = 1'b0;
  logic       enable = 1'b0;
  logic       fault = 1'b0;
  logic [9:0] target = '0;
  logic       target_valid = 1'b0;
  logic [9:0] d_halfbridge;
  logic       at_target;
  logic       fault_latched;

  duty_ramp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .clk_int      (clk_int),
    .enable       (enable),
    .fault        (fault),
    .target       (target),
    .target_valid (target_valid),
    .d_halfbridge (d_halfbridge),
    .at_target    (at_target),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int phase_cnt = 0;
  int half_per = 4;
  bit manual_clk = 1'b0;

  // Behavioural model: operating mode, duty and latched target as plain integers.
  int m_mode = M_IDLE;
  int m_duty = 0;
  int m_tgt  = 0;
  bit m_at   = 1'b0;
  bit m_fl   = 1'b0;
  bit hist [4] = '{default: 1'b0};  // clk_int samples at past edges, [3] newest

  int changes = 0;
  int first_val = 0;
  int prev_d = 0;
  int min_nz = 1024;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int limit(input int t);
    if (t == 0) return 0;
    if (t < DUTY_MIN) return DUTY_MIN;
    if (t > DUTY_MAX) return DUTY_MAX;
    return t;
  endfunction

  function automatic int approach(input int d, input int g);
    int delta, mag, r;
    if (d == g) return d;
    if (d == 0 && g > 0 && DUTY_MIN > STEP) return DUTY_MIN;
    delta = g - d;
    mag   = (delta < 0) ? -delta : delta;
    if (mag > STEP) mag = STEP;
    r = d + ((delta < 0) ? -mag : mag);
    if (g == 0 && r < DUTY_MIN) r = 0;
    if (r > DUTY_MAX) r = DUTY_MAX;
    return r;
  endfunction

  function automatic bit model_tick(input bit s);
    if (LAT == 0) return s && !hist[3];
    return hist[2] && !hist[1];
  endfunction

  function automatic bit gen_clk_int();
    if (manual_clk) return clk_int;
    return ((phase_cnt / half_per) % 2) == 1;
  endfunction

  function automatic bit peek_tick();
    return model_tick(gen_clk_int());
  endfunction

  task automatic model_edge(input bit tk);
    int goal;
    if (!rst_n) begin
      m_mode = M_IDLE; m_duty = 0; m_tgt = 0; m_at = 0; m_fl = 0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) hist[i] = hist[i+1];
    hist[3] = clk_int;
    if (fault) begin
      m_mode = M_FAULT; m_duty = 0; m_at = 0; m_fl = 1;
      return;
    end
    if (!ce) return;
    if (m_mode == M_FAULT) begin
      if (!enable) begin m_mode = M_IDLE; m_tgt = 0; m_fl = 0; end
      return;
    end
    if (target_valid) m_tgt = limit(int'(target));
    goal = enable ? m_tgt : 0;
    case (m_mode)
      M_IDLE: if (enable) m_mode = M_RAMP;
      M_RAMP: begin
        if (m_duty == goal) begin
          if (enable) begin m_mode = M_HOLD; m_at = 1; end
          else m_mode = M_IDLE;
        end
        if (tk) m_duty = approach(m_duty, goal);
      end
      default: begin
        if (!enable || m_duty != goal) begin m_mode = M_RAMP; m_at = 0; end
        if (tk) m_duty = approach(m_duty, goal);
      end
    endcase
  endtask

  task automatic cycle();
    bit tk;
    clk_int = gen_clk_int();
    phase_cnt++;
    tk = model_tick(clk_int);
    model_edge(tk);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog observed=%0d expected<=60000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    check("duty", 32'(d_halfbridge), 32'(m_duty));
    check("at_target", 32'(at_target), 32'(m_at));
    check("fault_latched", 32'(fault_latched), 32'(m_fl));
    if (int'(d_halfbridge) != prev_d) begin
      changes++;
      if (changes == 1) first_val = int'(d_halfbridge);
    end
    if (d_halfbridge != '0 && int'(d_halfbridge) < min_nz) min_nz = int'(d_halfbridge);
    prev_d = int'(d_halfbridge);
  endtask

  task automatic strobe(input int t);
    target = 10'(t);
    target_valid = 1'b1;
    cycle();
    target_valid = 1'b0;
  endtask

  initial begin
    int n, saved, floor_v;

    // Reset with noisy inputs
    enable = 1'b1; target = 10'd300; target_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_duty", 32'(d_halfbridge), 0);
    check("reset_at", 32'(at_target), 0);
    check("reset_fault", 32'(fault_latched), 0);
    target_valid = 1'b0;

    // Ramp 0 -> 200: jump to 50, then 4 per tick
    rst_n = 1'b1; enable = 1'b1;
    changes = 0; prev_d = 0;
    strobe(200);
    n = 0;
    while (!at_target && n < 800) begin cycle(); n++; end
    check("up_first_value", 32'(first_val), 50);
    check("up_tick_count", 32'(changes), 39);
    check("up_final", 32'(d_halfbridge), 200);
    check("up_hold", 32'(at_target), 1);

    // Retarget down to 100 from HOLD
    changes = 0;
    strobe(100);
    check("retarget_clears_at", 32'(at_target), 0);
    n = 0;
    while (!at_target && n < 800) begin cycle(); n++; end
    check("down_tick_count", 32'(changes), 25);
    check("down_final", 32'(d_halfbridge), 100);

    // Strobe coincident with tick
    strobe(200);
    changes = 0; n = 0;
    while (changes == 0 && n < 60) begin cycle(); n++; end
    check("coinc_pre", 32'(d_halfbridge), 104);
    n = 0;
    while (!peek_tick() && n < 30) begin cycle(); n++; end
    strobe(106);
    check("coinc_duty", 32'(d_halfbridge), 106);
    cycle();
    check("coinc_hold", 32'(at_target), 1);

    // Fault mid-ramp
    strobe(600);
    n = 0;
    while (d_halfbridge < 10'd500 && n < 2000) begin cycle(); n++; end
    check("fault_pre_ramp", 32'(d_halfbridge >= 10'd500), 1);
    fault = 1'b1; cycle(); fault = 1'b0;
    check("fault_duty", 32'(d_halfbridge), 0);
    check("fault_flag", 32'(fault_latched), 1);
    for (int i = 0; i < 20; i++) cycle();
    check("fault_sticky", 32'(fault_latched), 1);
    enable = 1'b0; cycle();
    check("fault_exit", 32'(fault_latched), 0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("fault_tgt_cleared_duty", 32'(d_halfbridge), 0);
    check("fault_tgt_cleared_hold", 32'(at_target), 1);

    // Upper clamp and shutdown ramp
    strobe(1023);
    n = 0;
    while (!at_target && n < 4000) begin cycle(); n++; end
    check("clamp_max", 32'(d_halfbridge), DUTY_MAX);
    enable = 1'b0; min_nz = 1024; n = 0;
    while (d_halfbridge != '0 && n < 4000) begin cycle(); n++; end
    floor_v = DUTY_MAX;
    while (floor_v - STEP >= DUTY_MIN) floor_v -= STEP;
    check("shutdown_zero", 32'(d_halfbridge), 0);
    check("shutdown_floor", 32'(min_nz), 32'(floor_v));
    for (int i = 0; i < 3; i++) cycle();

    // ce low freezes duty and ignores strobes
    enable = 1'b1;
    strobe(400);
    for (int i = 0; i < 30; i++) cycle();
    saved = int'(d_halfbridge);
    ce = 1'b0;
    strobe(700);
    for (int i = 0; i < 4 * half_per; i++) cycle();
    check("ce_freeze", 32'(d_halfbridge), 32'(saved));
    ce = 1'b1;

    // Tick latency from first edge sampling clk_int high
    manual_clk = 1'b1; clk_int = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    saved = int'(d_halfbridge);
    clk_int = 1'b1; n = 0;
    while (int'(d_halfbridge) == saved && n < 10) begin cycle(); n++; end
    check("tick_latency", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < 3; i++) cycle();
    manual_clk = 1'b0;

    // Reset mid-ramp
    rst_n = 1'b0; cycle();
    check("midramp_reset_duty", 32'(d_halfbridge), 0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      fault = ($urandom_range(0, 399) == 0);
      ce = ($urandom_range(0, 9) != 0);
      target_valid = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       target = '0;
        1:       target = 10'($urandom_range(0, 60));
        default: target = 10'($urandom_range(0, 1023));
      endcase
      rst_n = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 499) == 0) half_per = int'($urandom_range(2, 6));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
